hazard3_fetch_mem_model: RTL and testbench

Parametrised instruction-side memory responder for formal and simulation benches of hazard3_frontend. It models a single-port AHB-lite-style bus with a pipelined address phase and data phase, per-transfer wait states and a two-cycle error response. It returns read data that is a known function of the address. Benches attach it directly to the frontend mem_* ports and check fetched halfwords against a simple address-derived formula.

---
 rtl/hazard3_fetch_mem_model_pkg.sv | 24 ++
 rtl/hazard3_fetch_mem_model_if.sv | 22 ++
 rtl/hazard3_fetch_mem_wait_ctr.sv | 32 +++
 rtl/hazard3_fetch_mem_model.sv | 101 ++++++++++
 tb/tb_hazard3_fetch_mem_model.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hazard3_fetch_mem_model_pkg.sv
// Shared definitions for the hazard3 fetch-side memory model: FSM encoding,
// the address-derived data pattern, and the bus-error region predicate.
package hazard3_fetch_mem_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

    // Word holding halfword index h (even) in the low half and h+1 above it;
    // the carry out of address bit 16 is dropped on purpose.
    function automatic logic [31:0] fetch_pattern(input logic [16:0] addr);
        logic [15:0] h;
        h = {addr[16:2], 1'b0};
        return {h + 16'd1, h};
    endfunction

    function automatic logic in_err_region(input logic [63:0] addr, base, mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/hazard3_fetch_mem_model_if.sv
// Frontend-facing instruction bus: pipelined address phase plus data phase.
interface hazard3_fetch_mem_model_if #(
    parameter int W_ADDR = 32
);
    logic [W_ADDR-1:0] mem_addr;
    logic              mem_size;
    logic              mem_addr_vld;
    logic              mem_addr_rdy;
    logic [31:0]       mem_data;
    logic              mem_data_vld;
    logic              mem_data_err;

    modport master (
        output mem_addr, mem_size, mem_addr_vld,
        input  mem_addr_rdy, mem_data, mem_data_vld, mem_data_err
    );

    modport slave (
        input  mem_addr, mem_size, mem_addr_vld,
        output mem_addr_rdy, mem_data, mem_data_vld, mem_data_err
    );
endinterface

// File: rtl/hazard3_fetch_mem_wait_ctr.sv
// Loadable down-counter for data-phase wait states; flags when the value it
// is about to take is zero so the FSM can leave the stall one cycle early.
module hazard3_fetch_mem_wait_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_next
);
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (load)
            count_next = load_val;
        else if (dec && count != '0)
            count_next = count - 1'b1;
    end

    assign zero_next = (count_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_next;
    end
endmodule

// File: rtl/hazard3_fetch_mem_model.sv
// Instruction-side AHB-lite-style responder with per-transfer wait states,
// two-cycle error responses and address-derived read data.
module hazard3_fetch_mem_model
    import hazard3_fetch_mem_model_pkg::*;
#(
    parameter int          W_ADDR   = 32,
    parameter int          MAX_WAIT = 3,
    parameter int          W_WAIT   = 2,
    parameter logic [31:0] ERR_BASE = 32'hffff_0000,
    parameter logic [31:0] ERR_MASK = 32'hffff_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    hazard3_fetch_mem_model_if.slave      bus,
    input  logic [W_WAIT-1:0]             wait_sel,
    output logic                          dphase_busy,
    output logic [15:0]                   xfer_count
);
    fetch_state_e      state, state_next;
    logic              accept;
    logic              err_next;
    logic [W_WAIT-1:0] wcnt_load;
    logic [W_WAIT-1:0] wcnt;
    logic              wcnt_zero_next;
    // Only bits [16:0] feed the data pattern, so the rest are not kept.
    logic [16:0]       dp_addr;
    logic              dp_vld;
    logic              dp_err;
    logic              unused_size;

    // The frontend picks the halfword itself; the full word is always returned.
    assign unused_size = bus.mem_size;

    assign bus.mem_addr_rdy = (state == ST_IDLE) || (state == ST_DONE);
    assign accept           = bus.mem_addr_vld && bus.mem_addr_rdy;
    assign err_next         = in_err_region(64'(bus.mem_addr), 64'(ERR_BASE), 64'(ERR_MASK));
    assign wcnt_load        = (wait_sel > W_WAIT'(MAX_WAIT)) ? W_WAIT'(MAX_WAIT) : wait_sel;

    hazard3_fetch_mem_wait_ctr #(.W(W_WAIT)) u_wait_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_val  (wcnt_load),
        .dec       (state == ST_DATA),
        .count     (wcnt),
        .zero_next (wcnt_zero_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (!accept)
                    state_next = ST_IDLE;
                else if (!wcnt_zero_next)
                    state_next = ST_DATA;
                else
                    state_next = err_next ? ST_ERR1 : ST_DONE;
            end
            ST_DATA: if (wcnt_zero_next) state_next = dp_err ? ST_ERR1 : ST_DONE;
            ST_ERR1: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dp_addr    <= '0;
            dp_vld     <= 1'b0;
            dp_err     <= 1'b0;
            xfer_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                dp_vld  <= 1'b1;
                dp_addr <= bus.mem_addr[16:0];
                dp_err  <= err_next;
            end else if (bus.mem_addr_rdy) begin
                dp_vld  <= 1'b0;
            end
            if (bus.mem_data_vld && xfer_count != 16'hffff)
                xfer_count <= xfer_count + 16'd1;
        end
    end

    // Outputs come from the completing transfer's registers even while the
    // next transfer is being accepted in the same DONE cycle.
    assign bus.mem_data_vld = (state == ST_DONE) && dp_vld;
    assign bus.mem_data_err = bus.mem_data_vld && dp_err;
    assign bus.mem_data     = (bus.mem_data_vld && !dp_err) ? fetch_pattern(dp_addr) : 32'h0;
    assign dphase_busy      = dp_vld && (state != ST_IDLE);

`ifdef FORMAL
    always_comb begin
        if (state == ST_IDLE || state == ST_DATA)
            assert (!bus.mem_data_vld);
        assert (wcnt <= W_WAIT'(MAX_WAIT));
    end
`endif
endmodule

// File: tb/tb_hazard3_fetch_mem_model.sv
// Directed bench for hazard3_fetch_mem_model: three instances cover the
// default wait range, a clamped MAX_WAIT=2 and a zero-wait MAX_WAIT=0 bus.
module tb_hazard3_fetch_mem_model;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ws_m, ws_c, ws_z;
    logic        busy_m, busy_c, busy_z;
    logic [15:0] cnt_m, cnt_c, cnt_z;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hazard3_fetch_mem_model_if #(.W_ADDR(32)) bus_m ();
    hazard3_fetch_mem_model_if #(.W_ADDR(32)) bus_c ();
    hazard3_fetch_mem_model_if #(.W_ADDR(32)) bus_z ();

    hazard3_fetch_mem_model #(.MAX_WAIT(3)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bus_m), .wait_sel(ws_m),
        .dphase_busy(busy_m), .xfer_count(cnt_m));
    hazard3_fetch_mem_model #(.MAX_WAIT(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c), .wait_sel(ws_c),
        .dphase_busy(busy_c), .xfer_count(cnt_c));
    hazard3_fetch_mem_model #(.MAX_WAIT(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .bus(bus_z), .wait_sel(ws_z),
        .dphase_busy(busy_z), .xfer_count(cnt_z));

    task automatic do_reset();
        rst_n = 1'b0;
        bus_m.mem_addr_vld = 0; bus_c.mem_addr_vld = 0; bus_z.mem_addr_vld = 0;
        bus_m.mem_addr = 0; bus_c.mem_addr = 0; bus_z.mem_addr = 0;
        bus_m.mem_size = 1; bus_c.mem_size = 1; bus_z.mem_size = 1;
        ws_m = 0; ws_c = 0; ws_z = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_m.mem_addr_vld = 0; bus_c.mem_addr_vld = 0; bus_z.mem_addr_vld = 0;
        bus_m.mem_addr = 0; bus_c.mem_addr = 0; bus_z.mem_addr = 0;
        bus_m.mem_size = 1; bus_c.mem_size = 1; bus_z.mem_size = 1;
        ws_m = 0; ws_c = 0; ws_z = 0;
        @(negedge clk);
        n_tests++; if (bus_m.mem_addr_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy got=%b exp=1", bus_m.mem_addr_rdy); end
        n_tests++; if ({bus_m.mem_data_vld, bus_m.mem_data_err, busy_m} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%b exp=000", {bus_m.mem_data_vld, bus_m.mem_data_err, busy_m}); end
        n_tests++; if (bus_m.mem_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=00000000", bus_m.mem_data); end
        n_tests++; if (cnt_m !== 16'h0) begin n_fail++; $display("FAIL rst_count got=%h exp=0000", cnt_m); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0001_0000; exp_d[1] = 32'h0003_0002; exp_d[2] = 32'h0005_0004;
        do_reset();
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (bus_m.mem_addr_rdy !== 1'b1 || bus_m.mem_data_vld !== 1'b1) begin n_fail++; $display("FAIL zw_hs%0d got rdy=%b vld=%b exp 1 1", i, bus_m.mem_addr_rdy, bus_m.mem_data_vld); end
            n_tests++; if (bus_m.mem_data !== exp_d[i]) begin n_fail++; $display("FAIL zw_data%0d got=%h exp=%h", i, bus_m.mem_data, exp_d[i]); end
            if (i < 2) bus_m.mem_addr = 32'(4 * (i + 1));
            else bus_m.mem_addr_vld = 0;
        end
        @(negedge clk);
        n_tests++; if (bus_m.mem_data_vld !== 1'b0 || busy_m !== 1'b0) begin n_fail++; $display("FAIL zw_idle got vld=%b busy=%b exp 0 0", bus_m.mem_data_vld, busy_m); end
        n_tests++; if (cnt_m !== 16'd3) begin n_fail++; $display("FAIL zw_count got=%0d exp=3", cnt_m); end
    endtask

    task automatic test_wait_states();
        int stalls;
        do_reset();
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'h40; ws_m = 2'd3;
        @(negedge clk);
        bus_m.mem_addr_vld = 0;
        n_tests++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL ws_busy got=%b exp=1", busy_m); end
        stalls = 0;
        while (!bus_m.mem_addr_rdy && stalls < 10) begin
            n_tests++; if (bus_m.mem_data_vld !== 1'b0) begin n_fail++; $display("FAIL ws_early_vld stall=%0d got=1 exp=0", stalls); end
            stalls++; @(negedge clk);
        end
        n_tests++; if (stalls != 3) begin n_fail++; $display("FAIL ws_stalls got=%0d exp=3", stalls); end
        n_tests++; if (bus_m.mem_data_vld !== 1'b1 || bus_m.mem_data !== 32'h0021_0020) begin n_fail++; $display("FAIL ws_data got vld=%b data=%h exp 1 00210020", bus_m.mem_data_vld, bus_m.mem_data); end
        @(negedge clk);
        n_tests++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL ws_count got=%0d exp=1", cnt_m); end
    endtask

    task automatic test_error();
        int stalls;
        do_reset();
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'hffff_0010; ws_m = 0;
        @(negedge clk);
        bus_m.mem_addr_vld = 0;
        n_tests++; if (bus_m.mem_addr_rdy !== 1'b0 || bus_m.mem_data_vld !== 1'b0) begin n_fail++; $display("FAIL err_cyc1 got rdy=%b vld=%b exp 0 0", bus_m.mem_addr_rdy, bus_m.mem_data_vld); end
        @(negedge clk);
        n_tests++; if ({bus_m.mem_data_vld, bus_m.mem_data_err} !== 2'b11 || bus_m.mem_data !== 32'h0) begin n_fail++; $display("FAIL err_cyc2 got vld=%b err=%b data=%h exp 1 1 00000000", bus_m.mem_data_vld, bus_m.mem_data_err, bus_m.mem_data); end
        @(negedge clk);
        n_tests++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL err_count got=%0d exp=1", cnt_m); end
        // error after wait states: 2 DATA cycles plus ERR1
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'hffff_8000; ws_m = 2'd2;
        @(negedge clk);
        bus_m.mem_addr_vld = 0;
        stalls = 0;
        while (!bus_m.mem_addr_rdy && stalls < 10) begin stalls++; @(negedge clk); end
        n_tests++; if (stalls != 3 || bus_m.mem_data_err !== 1'b1) begin n_fail++; $display("FAIL err_wait got stalls=%0d err=%b exp 3 1", stalls, bus_m.mem_data_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'h0001_fffc; ws_m = 0;
        @(negedge clk);
        bus_m.mem_addr_vld = 0;
        n_tests++; if (bus_m.mem_data !== 32'hffff_fffe || bus_m.mem_data_err !== 1'b0) begin n_fail++; $display("FAIL wrap got data=%h err=%b exp ffff_fffe 0", bus_m.mem_data, bus_m.mem_data_err); end
    endtask

    task automatic test_clamp();
        int stalls_c, stalls_z;
        do_reset();
        bus_c.mem_addr_vld = 1; bus_c.mem_addr = 32'h8; ws_c = 2'd3;
        bus_z.mem_addr_vld = 1; bus_z.mem_addr = 32'hc; ws_z = 2'd3;
        @(negedge clk);
        bus_c.mem_addr_vld = 0; bus_z.mem_addr_vld = 0;
        n_tests++; if (bus_z.mem_data_vld !== 1'b1 || bus_z.mem_data !== 32'h0007_0006) begin n_fail++; $display("FAIL clamp0 got vld=%b data=%h exp 1 00070006", bus_z.mem_data_vld, bus_z.mem_data); end
        stalls_c = 0;
        while (!bus_c.mem_addr_rdy && stalls_c < 10) begin stalls_c++; @(negedge clk); end
        n_tests++; if (stalls_c != 2 || bus_c.mem_data !== 32'h0005_0004) begin n_fail++; $display("FAIL clamp2 got stalls=%0d data=%h exp 2 00050004", stalls_c, bus_c.mem_data); end
        // error on a MAX_WAIT=0 bus still takes the ERR1 cycle
        bus_z.mem_addr_vld = 1; bus_z.mem_addr = 32'hffff_0000; ws_z = 2'd3;
        @(negedge clk);
        bus_z.mem_addr_vld = 0;
        stalls_z = 0;
        while (!bus_z.mem_addr_rdy && stalls_z < 10) begin stalls_z++; @(negedge clk); end
        n_tests++; if (stalls_z != 1 || bus_z.mem_data_err !== 1'b1) begin n_fail++; $display("FAIL clamp0_err got stalls=%0d err=%b exp 1 1", stalls_z, bus_z.mem_data_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'h100; ws_m = 2'd1;
        @(negedge clk);
        bus_m.mem_addr = 32'h104; ws_m = 0;
        n_tests++; if (bus_m.mem_addr_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", bus_m.mem_addr_rdy); end
        @(negedge clk);
        n_tests++; if (bus_m.mem_addr_rdy !== 1'b1 || bus_m.mem_data !== 32'h0081_0080) begin n_fail++; $display("FAIL b2b_first got rdy=%b data=%h exp 1 00810080", bus_m.mem_addr_rdy, bus_m.mem_data); end
        @(negedge clk);
        bus_m.mem_addr_vld = 0;
        n_tests++; if (bus_m.mem_data_vld !== 1'b1 || bus_m.mem_data !== 32'h0083_0082) begin n_fail++; $display("FAIL b2b_second got vld=%b data=%h exp 1 00830082", bus_m.mem_data_vld, bus_m.mem_data); end
        @(negedge clk);
        n_tests++; if (cnt_m !== 16'd2 || bus_m.mem_data_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_end got count=%0d vld=%b exp 2 0", cnt_m, bus_m.mem_data_vld); end
    endtask

    task automatic test_reset_mid();
        logic seen_vld;
        do_reset();
        bus_m.mem_addr_vld = 1; bus_m.mem_addr = 32'h40; ws_m = 2'd3;
        @(negedge clk);
        bus_m.mem_addr_vld = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus_m.mem_addr_rdy !== 1'b1 || busy_m !== 1'b0 || bus_m.mem_data_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_async got rdy=%b busy=%b vld=%b exp 1 0 0", bus_m.mem_addr_rdy, busy_m, bus_m.mem_data_vld); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_vld |= bus_m.mem_data_vld;
        end
        n_tests++; if (seen_vld !== 1'b0 || cnt_m !== 16'd0) begin n_fail++; $display("FAIL rmid_after got seen_vld=%b count=%0d exp 0 0", seen_vld, cnt_m); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_error();
        test_wrap();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
